cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Memory-side arbiter directly downstream of the instruction and data caches. It accepts word-granular requests from the icache and dcache ports and serialises them onto the single RAM port. It holds the dcache grant for the whole of a multi-word writeback/fill sequence, and returns RAM data and wait status to the granted requester only.

## Interface
Parameters:
- RAM_ADDR_W, 32, width of RAM/cache word addresses.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; 0 in the cycle its word completes.
- iload  out  32  read data to icache; ramload while I granted, else 0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; 0 in the cycle its word completes.
- dload  out  32  read data to dcache; ramload while D granted, else 0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- States: IDLE, DGRANT, IGRANT. The grant is registered and changes only on a transition out of IDLE or back into it.
- IDLE:
  - Drives no RAM request.
  - If (dREN|dWEN) and not fairness-override → DGRANT.
  - Else if iREN → IGRANT.
  - Else stay in IDLE.
- DGRANT:
  - Passes ramREN=dREN&~dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - dwait = ~(ramstate==ACCESS).
  - Stays in DGRANT while dREN|dWEN is high, across any number of completed words. This keeps WB1→WB2→LD1→LD2 sequences atomic.
  - → IDLE in the cycle after the dcache drops both strobes.
- IGRANT:
  - Passes ramREN=iREN, ramaddr=iaddr, ramWEN=0, ramstore=0.
  - iwait = ~(ramstate==ACCESS).
  - → IDLE after one completed word (ramstate==ACCESS), or when iREN drops.
- Non-granted requester: wait=1, load=0.
- ramstate ERROR is treated as BUSY: wait stays 1 and the grant is held.
- The dcache halt-count write (address 0x3100) is an ordinary write with no special handling.
- Address or data changes while granted are passed through combinationally. RAM is responsible for restarting.

## Timing
- Reset values: state=IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, fairness bit=0.
- Request raised in IDLE at cycle 0: the grant state is entered at cycle 1 and RAM strobes are driven from cycle 1. Minimum latency is wait=0 in cycle 1, if RAM reports ACCESS immediately.
- A requester completes a word at the rising edge where its wait=0. The next word's address is presented in the following cycle while the grant is held.
- Simultaneous dcache and icache requests in IDLE: priority as in Configuration.
- Icache back-to-back fetches return to IDLE between words, which costs one arbitration cycle per word.
- Reset mid-transfer: outputs drop to reset values asynchronously. A partial RAM write is not replayed.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A fairness bit is set when the arbiter leaves DGRANT while iREN was high at any point during that grant.
  - On the next simultaneous request in IDLE, icache wins and the bit is cleared on entry to IGRANT.
- ARB_FAIRNESS_EN undefined:
  - Strict dcache priority; the fairness bit is absent.
  - The icache can be starved by continuous dcache traffic.

## Structure
- In shared package cpu_types_pkg: ramstate_t (2-bit enum FREE/BUSY/ACCESS/ERROR) and word_t.
- Local to the module: arb_state_t (IDLE/DGRANT/IGRANT).
- Single module with no sub-module. Priority selection is one always_comb next-state block; output muxing is a second always_comb.

## Test plan
- Reset, then idle: all RAM strobes 0, iwait=dwait=1, loads 0; state stays IDLE for 10 cycles.
- Icache read of 0x40 with RAM ACCESS after 2 BUSY cycles, ramload=0x2108FFFF:
  - ramREN=1 and ramaddr=0x40 from cycle 1.
  - iwait=0 and iload=0x2108FFFF in cycle 3.
  - IDLE in cycle 4.
- Dcache 4-word sequence (write 0x100, write 0x104, read 0x200, read 0x204) with iREN high throughout:
  - Grant is held in DGRANT for all 4 words.
  - iwait stays 1 until the dcache drops its strobes, then IGRANT follows.
- Simultaneous iREN and dREN in IDLE:
  - ARB_FAIRNESS_EN undefined: DGRANT.
  - ARB_FAIRNESS_EN defined, after a prior D grant that starved I: IGRANT.
- ramstate=ERROR for 3 cycles, then ACCESS during DGRANT: dwait=1 for all 3 cycles, then 0; the grant is never lost.
- nRST asserted mid-DGRANT with ramWEN=1: ramWEN drops to 0 immediately and the state is IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared CPU/memory types: RAM word and RAM handshake state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Serialises icache/dcache word requests onto one RAM port,
//             holding the dcache grant across multi-word sequences.
//  Options  : ARB_FAIRNESS_EN - icache wins the next tie after being starved.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int RAM_ADDR_W = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  iREN,
   input  logic [RAM_ADDR_W-1:0] iaddr,
   output logic                  iwait,
   output word_t                 iload,
   input  logic                  dREN,
   input  logic                  dWEN,
   input  logic [RAM_ADDR_W-1:0] daddr,
   input  word_t                 dstore,
   output logic                  dwait,
   output word_t                 dload,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [RAM_ADDR_W-1:0] ramaddr,
   output word_t                 ramstore,
   input  word_t                 ramload,
   input  ramstate_t             ramstate
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

   arb_state_t r_state;
   arb_state_t w_next_state;
   logic       w_dreq;
   logic       w_ram_access;
   logic       w_fair_override;

   assign w_dreq       = dREN | dWEN;
   // ERROR is deliberately not ACCESS: the requester keeps waiting and keeps the grant.
   assign w_ram_access = (ramstate == ACCESS);

`ifdef ARB_FAIRNESS_EN
   logic r_fair;
   logic r_i_seen;

   // r_i_seen remembers icache demand seen during the current dcache grant.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_fair   <= 1'b0;
         r_i_seen <= 1'b0;
      end else begin
         if (r_state == IDLE && w_next_state == DGRANT)
            r_i_seen <= 1'b0;
         else if (r_state == DGRANT)
            r_i_seen <= r_i_seen | iREN;

         if (r_state == IDLE && w_next_state == IGRANT)
            r_fair <= 1'b0;
         else if (r_state == DGRANT && w_next_state == IDLE)
            r_fair <= r_fair | r_i_seen | iREN;
      end
   end

   assign w_fair_override = r_fair & iREN;
`else
   assign w_fair_override = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_dreq && !w_fair_override)
               w_next_state = DGRANT;
            else if (iREN)
               w_next_state = IGRANT;
         end
         DGRANT: begin
            if (!w_dreq)
               w_next_state = IDLE;
         end
         IGRANT: begin
            if (w_ram_access || !iREN)
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      case (r_state)
         DGRANT: begin
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dwait    = ~w_ram_access;
            dload    = ramload;
         end
         IGRANT: begin
            ramREN   = iREN;
            ramaddr  = iaddr;
            iwait    = ~w_ram_access;
            iload    = ramload;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Directed plus random check of cache_mem_arbiter against an
//             ownership-level reference model of the RAM port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;
   import cpu_types_pkg::*;

`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   localparam int OWN_NONE = 0;
   localparam int OWN_D    = 1;
   localparam int OWN_I    = 2;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic        iwait;
   word_t       iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   word_t       dstore = '0;
   logic        dwait;
   word_t       dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   word_t       ramstore;
   word_t       ramload = '0;
   ramstate_t   ramstate = FREE;

   int tests = 0;
   int fails = 0;

   // Reference model: who owns the RAM port and the starvation memory.
   int m_own   = OWN_NONE;
   bit m_fair  = 1'b0;
   bit m_iseen = 1'b0;

   always #5 CLK = ~CLK;

   cache_mem_arbiter #(.RAM_ADDR_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] ds,
                        input ramstate_t rs, input logic [31:0] rl);
      iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
      ramstate = rs; ramload = rl;
   endtask

   // Let combinational outputs settle, then compare them with the model.
   task automatic settle();
      logic        e_ren, e_wen, e_iw, e_dw;
      logic [31:0] e_addr, e_store, e_il, e_dl;
      bit          acc;
      #3;
      acc = (ramstate == ACCESS);
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
      e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0;
      if (m_own == OWN_D) begin
         e_wen = dWEN;  e_ren = dREN && !dWEN;
         e_addr = daddr; e_store = dstore;
         e_dw = !acc;   e_dl = ramload;
      end else if (m_own == OWN_I) begin
         e_ren = iREN;  e_addr = iaddr;
         e_iw = !acc;   e_il = ramload;
      end
      chk("ram_req",   {ramREN, ramWEN, ramaddr}, {e_ren, e_wen, e_addr});
      chk("ram_store", ramstore, e_store);
      chk("i_side",    {iwait, iload}, {e_iw, e_il});
      chk("d_side",    {dwait, dload}, {e_dw, e_dl});
   endtask

   // Apply the arbitration rules to this cycle's inputs and cross the edge.
   task automatic advance();
      int n_own;
      bit n_fair, n_iseen, dreq;
      n_own = m_own; n_fair = m_fair; n_iseen = m_iseen;
      dreq = dREN || dWEN;
      if (m_own == OWN_NONE) begin
         if (dreq && !(FAIR && m_fair && iREN)) begin
            n_own = OWN_D; n_iseen = 0;
         end else if (iREN) begin
            n_own = OWN_I; n_fair = 0;
         end
      end else if (m_own == OWN_D) begin
         n_iseen = m_iseen || iREN;
         if (!dreq) begin
            n_own = OWN_NONE;
            if (FAIR) n_fair = m_fair || n_iseen;
         end
      end else begin
         if (ramstate == ACCESS || !iREN) n_own = OWN_NONE;
      end
      @(posedge CLK);
      #1;
      m_own = n_own; m_fair = n_fair; m_iseen = n_iseen;
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   initial begin
      bit d_on;

      // Reset values while nRST is held low.
      #2;
      chk("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 64'd0);
      chk("rst_wait", {iwait, dwait}, 2'b11);
      chk("rst_load", {iload, dload}, 64'd0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      for (int k = 0; k < 10; k++) cycle();

      // Icache read of 0x40: two BUSY cycles, then ACCESS.
      drive(1, 32'h40, 0, 0, 0, 0, FREE, 0);  cycle();
      drive(1, 32'h40, 0, 0, 0, 0, BUSY, 0);  settle();
      chk("i_c1_req", {ramREN, ramaddr, iwait}, {1'b1, 32'h40, 1'b1});
      advance();
      drive(1, 32'h40, 0, 0, 0, 0, BUSY, 0);  cycle();
      drive(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h2108FFFF); settle();
      chk("i_c3_done", {iwait, iload}, {1'b0, 32'h2108FFFF});
      advance();
      drive(1, 32'h40, 0, 0, 0, 0, FREE, 0);  settle();
      chk("i_c4_idle", {ramREN, iwait}, 2'b01);
      advance();
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      for (int k = 0; k < 3; k++) cycle();

      // Dcache WB1, WB2, LD1, LD2 with the icache requesting throughout.
      drive(1, 32'h80, 0, 1, 32'h100, 32'hAAAA0001, FREE, 0); cycle();
      for (int w = 0; w < 4; w++) begin
         logic [31:0] a;
         a = (w < 2) ? 32'h100 + 32'(4 * w) : 32'h200 + 32'(4 * (w - 2));
         drive(1, 32'h80, w >= 2, w < 2, a, 32'hAAAA0000 + 32'(w), BUSY, 32'h5000 + 32'(w));
         settle();
         chk("d_seq_busy", {ramWEN, ramREN, ramaddr, iwait, dwait},
             {w < 2, w >= 2, a, 1'b1, 1'b1});
         advance();
         drive(1, 32'h80, w >= 2, w < 2, a, 32'hAAAA0000 + 32'(w), ACCESS, 32'h5000 + 32'(w));
         settle();
         chk("d_seq_done", {dwait, iwait, dload}, {1'b0, 1'b1, 32'h5000 + 32'(w)});
         advance();
      end
      drive(1, 32'h80, 0, 0, 0, 0, FREE, 0);  settle();
      chk("d_drop_iwait", iwait, 1'b1);
      advance();
      cycle();
      drive(1, 32'h80, 0, 0, 0, 0, BUSY, 0);  settle();
      chk("i_after_d", {ramREN, ramaddr}, {1'b1, 32'h80});
      advance();
      drive(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h77); cycle();
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      for (int k = 0; k < 2; k++) cycle();

      // D grant that starves I, then a simultaneous request.
      drive(1, 32'h44, 1, 0, 32'h300, 0, FREE, 0); cycle();
      drive(1, 32'h44, 1, 0, 32'h300, 0, ACCESS, 32'h9); cycle();
      drive(0, 0, 0, 0, 0, 0, FREE, 0); cycle();
      cycle();
      drive(1, 32'h44, 1, 0, 32'h304, 0, BUSY, 0); cycle();
      settle();
      chk("tie_winner", ramaddr, FAIR ? 64'h44 : 64'h304);
      advance();
      drive(1, 32'h44, 1, 0, 32'h304, 0, ACCESS, 32'h1);
      for (int k = 0; k < 3; k++) cycle();
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      for (int k = 0; k < 3; k++) cycle();

      // ERROR is a stall, not a loss of grant.
      drive(0, 0, 1, 0, 32'h400, 0, FREE, 0); cycle();
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'h48, 1, 0, 32'h400, 0, ERROR, 32'hEE);
         settle();
         chk("err_stall", {dwait, ramREN, ramaddr}, {1'b1, 1'b1, 32'h400});
         advance();
      end
      drive(1, 32'h48, 1, 0, 32'h400, 0, ACCESS, 32'hEE); settle();
      chk("err_then_acc", {dwait, dload}, {1'b0, 32'hEE});
      advance();
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      for (int k = 0; k < 3; k++) cycle();

      // Asynchronous reset in the middle of a dcache write.
      drive(0, 0, 0, 1, 32'h3100, 32'h1234, FREE, 0); cycle();
      drive(0, 0, 0, 1, 32'h3100, 32'h1234, BUSY, 0); settle();
      chk("pre_rst_wen", ramWEN, 1'b1);
      nRST = 1'b0;
      #1;
      chk("rst_drop_wen", {ramWEN, ramaddr, dwait}, {1'b0, 32'h0, 1'b1});
      m_own = OWN_NONE; m_fair = 0; m_iseen = 0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      settle();
      chk("post_rst_idle", {ramWEN, ramREN}, 2'b00);
      advance();
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      for (int k = 0; k < 2; k++) cycle();

      // Random traffic; dcache requests come in bursts.
      d_on = 0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 5) == 0) d_on = !d_on;
         drive($urandom_range(0, 1) == 1, $urandom,
               d_on && ($urandom_range(0, 1) == 1), d_on && ($urandom_range(0, 2) == 0),
               $urandom, $urandom, ramstate_t'($urandom_range(0, 3)), $urandom);
         if (d_on && !dREN && !dWEN) dREN = 1'b1;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
